// File: rtl/sgd_x_send_back_sequencer.sv
// sgd_x_send_back_sequencer
// Drains the per-engine x-update FIFOs (read side on the DMA clock) and
// turns them into one host-memory write per epoch: a one-cycle command
// (start/addr/length) followed by the model lines in model order
// (engine 0 lines 0..L-1, engine 1 lines 0..L-1, ... chunk by chunk).
module sgd_x_send_back_sequencer #(
  parameter int ENGINE_NUM        = 8,
  parameter int LINES_PER_ENGINE  = 4,
  parameter int FEATURES_PER_LINE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      started,
  input  logic [63:0]               addr_model,
  input  logic [31:0]               dimension,
  input  logic [31:0]               numEpochs,
  input  logic [ENGINE_NUM*512-1:0] x_to_mem_rd_data,
  input  logic [ENGINE_NUM-1:0]     x_to_mem_empty,
  output logic [ENGINE_NUM-1:0]     x_to_mem_rd_en,
  output logic                      x_data_send_back_start,
  output logic [63:0]               x_data_send_back_addr,
  output logic [31:0]               x_data_send_back_length,
  output logic [511:0]              x_data_out,
  output logic                      x_data_out_valid,
  input  logic                      x_data_out_almost_full,
  output logic                      send_back_done,
  output logic [31:0]               lines_sent
);

  localparam int CHUNK_FEAT      = ENGINE_NUM * LINES_PER_ENGINE * FEATURES_PER_LINE;
  localparam int LINES_PER_CHUNK = ENGINE_NUM * LINES_PER_ENGINE;
  localparam int ENG_W           = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int INNER_W         = (LINES_PER_ENGINE > 1) ? $clog2(LINES_PER_ENGINE) : 1;

  localparam logic [32:0]        CHUNK_FEAT_33 = 33'(CHUNK_FEAT);
  localparam logic [31:0]        CHUNK_BYTES   = 32'(LINES_PER_CHUNK * 64);
  localparam logic [ENG_W-1:0]   ENG_LAST      = ENG_W'(ENGINE_NUM - 1);
  localparam logic [INNER_W-1:0] INNER_LAST    = INNER_W'(LINES_PER_ENGINE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          chunks_q, chunks_d;
  logic [31:0]          len_q, len_d;
  logic [63:0]          addr_run_q, addr_run_d;
  logic [INNER_W-1:0]   inner_q, inner_d;
  logic [ENG_W-1:0]     eng_q, eng_d;
  logic [31:0]          chunk_q, chunk_d;
  logic [31:0]          epoch_q, epoch_d;
  logic                 start_q, start_d;
  logic [63:0]          cmd_addr_q, cmd_addr_d;
  logic [31:0]          cmd_len_q, cmd_len_d;
  logic                 vld_p0_q, vld_p0_d;
  logic [ENG_W-1:0]     eng_p0_q, eng_p0_d;
  logic                 vld_p1_q, vld_p1_d;
  logic [511:0]         data_p1_q, data_p1_d;
  logic                 done_q, done_d;
  logic [31:0]          lines_q, lines_d;

  logic [31:0]          chunks_calc;
  logic [31:0]          length_calc;
  logic                 empty_sel;
  logic                 issue;
  logic [511:0]         slice_sel;

  // Job geometry: ceil over a 33-bit sum so an all-ones dimension cannot wrap;
  // a zero dimension still yields one chunk.
  always_comb begin
    chunks_calc = 32'(({1'b0, dimension} + CHUNK_FEAT_33 - 33'd1) / CHUNK_FEAT_33);
    if (chunks_calc == 32'd0) begin
      chunks_calc = 32'd1;
    end
    length_calc = chunks_calc * CHUNK_BYTES;
  end

  // Selected-engine empty flag and the FIFO slice chosen by the pipelined engine index.
  always_comb begin
    empty_sel = 1'b1;
    slice_sel = '0;
    for (int e = 0; e < ENGINE_NUM; e++) begin
      if (eng_q == ENG_W'(e)) begin
        empty_sel = x_to_mem_empty[e];
      end
      if (eng_p0_q == ENG_W'(e)) begin
        slice_sel = x_to_mem_rd_data[e*512 +: 512];
      end
    end
  end

  // Sequencer FSM: next state, counters, command, read enables and output pipeline.
  always_comb begin
    state_d    = state_q;
    chunks_d   = chunks_q;
    len_d      = len_q;
    addr_run_d = addr_run_q;
    inner_d    = inner_q;
    eng_d      = eng_q;
    chunk_d    = chunk_q;
    epoch_d    = epoch_q;
    start_d    = 1'b0;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    lines_d    = lines_q;
    issue      = 1'b0;
    x_to_mem_rd_en = '0;

    case (state_q)
      S_IDLE: begin
        inner_d    = '0;
        eng_d      = '0;
        chunk_d    = '0;
        epoch_d    = '0;
        addr_run_d = addr_model;
        chunks_d   = chunks_calc;
        len_d      = length_calc;
        if (started) begin
          state_d = (numEpochs != 32'd0) ? S_CMD : S_DONE;
        end
      end
      S_CMD: begin
        if (!x_to_mem_empty[0]) begin
          start_d    = 1'b1;
          cmd_addr_d = addr_run_q;
          cmd_len_d  = len_q;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        // Strictly in order: a starved engine stalls everything behind it.
        issue = !empty_sel && !x_data_out_almost_full;
        for (int e = 0; e < ENGINE_NUM; e++) begin
          x_to_mem_rd_en[e] = issue && (eng_q == ENG_W'(e));
        end
        if (issue) begin
          if (inner_q == INNER_LAST) begin
            inner_d = '0;
            if (eng_q == ENG_LAST) begin
              eng_d = '0;
              if (chunk_q == chunks_q - 32'd1) begin
                chunk_d    = '0;
                addr_run_d = addr_run_q + {32'd0, len_q};
                epoch_d    = epoch_q + 32'd1;
                state_d    = (epoch_q + 32'd1 == numEpochs) ? S_DONE : S_CMD;
              end else begin
                chunk_d = chunk_q + 32'd1;
              end
            end else begin
              eng_d = eng_q + ENG_W'(1);
            end
          end else begin
            inner_d = inner_q + INNER_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!started) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    vld_p0_d  = issue;
    eng_p0_d  = eng_q;
    vld_p1_d  = vld_p0_q;
    data_p1_d = vld_p0_q ? slice_sel : data_p1_q;

    if (state_q == S_IDLE && started) begin
      lines_d = '0;
    end else if (vld_p0_q) begin
      lines_d = lines_q + 32'd1;
    end

    done_d = (state_d == S_DONE);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      inner_q    <= '0;
      eng_q      <= '0;
      chunk_q    <= '0;
      epoch_q    <= '0;
      start_q    <= 1'b0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      data_p1_q  <= '0;
      done_q     <= 1'b0;
      lines_q    <= '0;
    end else begin
      state_q    <= state_d;
      inner_q    <= inner_d;
      eng_q      <= eng_d;
      chunk_q    <= chunk_d;
      epoch_q    <= epoch_d;
      start_q    <= start_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      data_p1_q  <= data_p1_d;
      done_q     <= done_d;
      lines_q    <= lines_d;
    end
  end

  // Job parameters and the read-stage engine index; reloaded in IDLE, no reset needed.
  always_ff @(posedge clk) begin
    chunks_q   <= chunks_d;
    len_q      <= len_d;
    addr_run_q <= addr_run_d;
    eng_p0_q   <= eng_p0_d;
  end

  assign x_data_send_back_start  = start_q;
  assign x_data_send_back_addr   = cmd_addr_q;
  assign x_data_send_back_length = cmd_len_q;
  assign x_data_out              = data_p1_q;
  assign x_data_out_valid        = vld_p1_q;
  assign send_back_done          = done_q;
  assign lines_sent              = lines_q;

endmodule

// File: tb/tb_sgd_x_send_back_sequencer.sv
// Directed bench for sgd_x_send_back_sequencer with a FIFO model per engine.
module tb_sgd_x_send_back_sequencer;

  localparam int E = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             started = 1'b0;
  logic [63:0]      addr_model = '0;
  logic [31:0]      dimension = '0;
  logic [31:0]      numEpochs = '0;
  logic [E*512-1:0] rd_data;
  logic [E-1:0]     empty;
  logic [E-1:0]     rd_en;
  logic             sb_start;
  logic [63:0]      sb_addr;
  logic [31:0]      sb_len;
  logic [511:0]     dout;
  logic             dvld;
  logic             af;
  logic             done;
  logic [31:0]      lines_sent;

  sgd_x_send_back_sequencer #(
    .ENGINE_NUM(E), .LINES_PER_ENGINE(4), .FEATURES_PER_LINE(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .started(started), .addr_model(addr_model),
    .dimension(dimension), .numEpochs(numEpochs),
    .x_to_mem_rd_data(rd_data), .x_to_mem_empty(empty), .x_to_mem_rd_en(rd_en),
    .x_data_send_back_start(sb_start), .x_data_send_back_addr(sb_addr),
    .x_data_send_back_length(sb_len), .x_data_out(dout), .x_data_out_valid(dvld),
    .x_data_out_almost_full(af), .send_back_done(done), .lines_sent(lines_sent)
  );

  always #5 clk = ~clk;

  // Cycle counter and periodic back-pressure (10 high out of every 20 cycles)
  int cyc = 0;
  bit bp_mode = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  assign af = bp_mode && ((cyc % 20) >= 10);

  // FIFO model: standard-mode read, dout updates on the edge after rd_en
  logic [511:0] mem [E][1024];
  int wr_ptr [E];
  int rd_ptr [E];
  bit flush_req = 1'b0;
  int underflows = 0;

  always @(posedge clk) begin
    for (int e = 0; e < E; e++) begin
      if (flush_req) begin
        rd_ptr[e] <= wr_ptr[e];
      end else if (rd_en[e]) begin
        if (wr_ptr[e] == rd_ptr[e]) underflows <= underflows + 1;
        rd_data[e*512 +: 512] <= mem[e][rd_ptr[e] % 1024];
        rd_ptr[e] <= rd_ptr[e] + 1;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < E; e++) empty[e] = (wr_ptr[e] == rd_ptr[e]);
  end

  // Output monitor, sampled on the falling edge
  logic [511:0] vlog [$];
  int           vcyc [$];
  logic [63:0]  saddr [$];
  logic [31:0]  slen [$];
  int           scyc [$];
  int rd_cnt = 0, multi_rd = 0, bp_viol = 0, af_run = 0;

  always @(negedge clk) begin
    if (dvld) begin
      vlog.push_back(dout);
      vcyc.push_back(cyc);
    end
    if (sb_start) begin
      saddr.push_back(sb_addr);
      slen.push_back(sb_len);
      scyc.push_back(cyc);
    end
    if (|rd_en) rd_cnt <= rd_cnt + 1;
    if ($countones(rd_en) > 1) multi_rd <= multi_rd + 1;
    bp_viol <= bp_viol + int'(af && (|rd_en)) + int'(dvld && af && af_run >= 2);
    af_run  <= af ? af_run + 1 : 0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input int scen, input int idx, input int e, input int k);
    logic [31:0] w;
    w = {8'(scen), 8'(idx), 8'(e), 8'(k)};
    return {16{w}};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int e, input logic [511:0] d);
    mem[e][wr_ptr[e] % 1024] = d;
    wr_ptr[e] = wr_ptr[e] + 1;
  endtask

  // Load every FIFO with the lines it owes, in model order; skip_eng stays empty.
  task automatic fill(input int scen, input int epochs, input int chunks, input int skip_eng);
    for (int ep = 0; ep < epochs; ep++)
      for (int ch = 0; ch < chunks; ch++)
        for (int e = 0; e < E; e++)
          for (int k = 0; k < 4; k++)
            if (e != skip_eng) push(e, make_line(scen, ep*chunks + ch, e, k));
  endtask

  task automatic start_job(input logic [63:0] a, input logic [31:0] dim, input logic [31:0] ep);
    addr_model = a;
    dimension  = dim;
    numEpochs  = ep;
    started    = 1'b1;
  endtask

  task automatic finish_job(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_done"}, done, 1);
    tick(3);
    started = 1'b0;
    tick(2);
  endtask

  task automatic verify(input string tag, input int vb, input int sb, input int scen,
                        input int epochs, input int chunks, input logic [63:0] addr0,
                        input logic [31:0] len);
    int lpe, bad, k, e, ch, ep, gap;
    lpe = chunks * 32;
    check({tag, "_starts"}, saddr.size() - sb, epochs);
    for (int i = 0; i < epochs; i++) begin
      if (sb + i < saddr.size()) begin
        check({tag, "_addr"}, saddr[sb+i], addr0 + 64'(i) * 64'(len));
        check({tag, "_len"}, slen[sb+i], len);
        if (vb + i*lpe < vcyc.size()) begin
          gap = vcyc[vb + i*lpe] - scyc[sb+i];
          check({tag, "_start_lead"}, gap >= 2, 1);
        end
      end
    end
    check({tag, "_count"}, vlog.size() - vb, epochs * lpe);
    bad = 0;
    for (int i = 0; i < epochs * lpe; i++) begin
      k  = i % 4;
      e  = (i / 4) % E;
      ch = (i / 32) % chunks;
      ep = i / lpe;
      if (vb + i >= vlog.size()) bad++;
      else if (vlog[vb+i] !== make_line(scen, ep*chunks + ch, e, k)) bad++;
    end
    check({tag, "_order_bad"}, bad, 0);
    check({tag, "_lines_sent"}, lines_sent, epochs * lpe);
  endtask

  initial begin
    int vb, sb, rc, b0, vs, ss, n;

    // Reset state
    tick(3);
    check("rst_start", sb_start, 0);
    check("rst_valid", dvld, 0);
    check("rst_done", done, 0);
    check("rst_lines", lines_sent, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_dout", |dout, 0);
    check("rst_addr", sb_addr, 0);
    rst_n = 1'b1;
    tick(1);

    // Single chunk
    fill(1, 1, 1, -1);
    vb = vlog.size(); sb = saddr.size();
    start_job(64'h1000, 32'd512, 32'd1);
    finish_job("single", 400);
    verify("single", vb, sb, 1, 1, 1, 64'h1000, 32'd2048);

    // Multi-chunk, multi-epoch
    fill(2, 3, 2, -1);
    vb = vlog.size(); sb = saddr.size();
    start_job(64'h1000, 32'd1000, 32'd3);
    finish_job("multi", 1500);
    verify("multi", vb, sb, 2, 3, 2, 64'h1000, 32'd4096);

    // Back-pressure
    fill(3, 1, 2, -1);
    vb = vlog.size(); sb = saddr.size(); b0 = bp_viol;
    bp_mode = 1'b1;
    start_job(64'h8000, 32'd1000, 32'd1);
    finish_job("bp", 1500);
    bp_mode = 1'b0;
    verify("bp", vb, sb, 3, 1, 2, 64'h8000, 32'd4096);
    check("bp_violations", bp_viol - b0, 0);

    // Starvation: FIFO 3 empty
    fill(4, 1, 1, 3);
    vb = vlog.size(); sb = saddr.size();
    start_job(64'h4000, 32'd512, 32'd1);
    tick(60);
    check("starve_stall_count", vlog.size() - vb, 12);
    if (vlog.size() > 0) check("starve_last_line", vlog[vlog.size()-1] == make_line(4, 0, 2, 3), 1);
    check("starve_rd_en", rd_en, 0);
    for (int k = 0; k < 4; k++) push(3, make_line(4, 0, 3, k));
    finish_job("starve", 400);
    verify("starve", vb, sb, 4, 1, 1, 64'h4000, 32'd2048);

    // Zero epochs
    rc = rd_cnt; sb = saddr.size();
    start_job(64'h5000, 32'd512, 32'd0);
    tick(2);
    check("zero_done", done, 1);
    check("zero_starts", saddr.size() - sb, 0);
    check("zero_rd_en", rd_cnt - rc, 0);
    started = 1'b0;
    tick(2);
    check("zero_idle_done", done, 0);

    // Dimension 0 still sends one chunk
    fill(6, 1, 1, -1);
    vb = vlog.size(); sb = saddr.size();
    start_job(64'h0, 32'd0, 32'd1);
    finish_job("dim0", 400);
    verify("dim0", vb, sb, 6, 1, 1, 64'h0, 32'd2048);

    // Reset mid-stream, all-ones dimension (length truncates to 0)
    fill(7, 1, 1, -1);
    vb = vlog.size(); sb = saddr.size();
    start_job(64'h2000, 32'hFFFF_FFFF, 32'd1);
    n = 0;
    while (vlog.size() - vb < 10 && n < 200) begin
      tick(1);
      n++;
    end
    check("rst_mid_reached", vlog.size() - vb >= 10, 1);
    check("big_dim_starts", saddr.size() - sb, 1);
    if (saddr.size() > sb) begin
      check("big_dim_len", slen[sb], 32'd0);
      check("big_dim_addr", saddr[sb], 64'h2000);
    end
    rst_n = 1'b0;
    started = 1'b0;
    tick(1);
    check("rst_mid_valid", dvld, 0);
    check("rst_mid_start", sb_start, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_lines", lines_sent, 0);
    check("rst_mid_rd_en", rd_en, 0);
    check("rst_mid_dout", |dout, 0);
    check("rst_mid_addr", sb_addr, 0);
    check("rst_mid_len", sb_len, 0);
    vs = vlog.size(); ss = saddr.size();
    tick(3);
    check("rst_mid_no_valid", vlog.size() - vs, 0);
    check("rst_mid_no_start", saddr.size() - ss, 0);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    rst_n = 1'b1;
    tick(1);

    // Rerun of the single-chunk job after the abort
    fill(8, 1, 1, -1);
    vb = vlog.size(); sb = saddr.size();
    start_job(64'h1000, 32'd512, 32'd1);
    finish_job("rerun", 400);
    verify("rerun", vb, sb, 8, 1, 1, 64'h1000, 32'd2048);

    check("fifo_underflow", underflows, 0);
    check("one_hot_rd_en", multi_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
